// File: rtl/matrix_pkg.sv
// Shared register addresses, word type and sequencer states for the LED matrix driver.
package matrix_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef logic [15:0] mword_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_INTENS,
    ST_FRAME,
    ST_WAIT_WORD
  } seq_state_t;

  function automatic mword_t mk_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/matrix_shift.sv
// 16-bit MSB-first serializer: cs low for 16 cycles, then GAP_CYCLES high before the next word.
module matrix_shift
  import matrix_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic   clk_9m,
  input  logic   pll_rst,
  input  logic   start,
  input  mword_t word,
  output logic   done,
  output logic   busy,
  output logic   cs,
  output logic   dout
);

  localparam int unsigned CW = $clog2(16 + GAP_CYCLES);

  logic [CW-1:0] cnt;
  logic [15:0]   shreg;
  logic          last;

  // done leads the final gap cycle by one so the sequencer can present the
  // next start exactly in that final cycle, keeping words back-to-back.
  assign last = busy && (cnt == CW'(15 + GAP_CYCLES));
  assign done = busy && (cnt == CW'(14 + GAP_CYCLES));

  always_ff @(posedge clk_9m) begin
    if (!pll_rst) begin
      cs    <= 1'b1;
      dout  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
    end else if (start && (!busy || last)) begin
      cs    <= 1'b0;
      dout  <= word[15];
      shreg <= {word[14:0], 1'b0};
      busy  <= 1'b1;
      cnt   <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(15)) begin
        cs   <= 1'b1;
        dout <= 1'b0;
      end else if (cnt < CW'(15)) begin
        dout  <= shreg[15];
        shreg <= {shreg[14:0], 1'b0};
      end
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_seq.sv
// LED matrix sequencer: power-up init, 8-row frame buffer, periodic refresh and intensity updates.
module matrix_seq
  import matrix_pkg::*;
#(
  parameter logic [3:0]  INTENSITY   = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT  = 3'd7,
  parameter int unsigned REFRESH_DIV = 9000,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk_9m,
  input  logic       pll_rst,
  input  logic       row_we,
  input  logic [2:0] row_addr,
  input  logic [7:0] row_data,
  input  logic       intensity_we,
  input  logic [3:0] intensity,
  output logic       busy,
  output logic       init_done,
  output logic       cs,
  output logic       dout
);

  localparam int unsigned TW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_DIV - 1);

  seq_state_t    state, state_nx, ret_state, ret_nx;
  logic [3:0]    step;
  logic          armed;
  logic [3:0]    intens_q;
  logic          int_pend, frame_pend;
  logic [TW-1:0] timer;
  logic          expire;
  logic [7:0]    fbuf [8];

  logic          start, shift_done;
  mword_t        word;
  logic          step_inc, step_clr, int_clr, frm_clr, done_set;
  logic [3:0]    digit_addr;

  matrix_shift #(.GAP_CYCLES(GAP_CYCLES)) u_shift (
    .clk_9m  (clk_9m),
    .pll_rst (pll_rst),
    .start   (start),
    .word    (word),
    .done    (shift_done),
    .busy    (busy),
    .cs      (cs),
    .dout    (dout)
  );

  assign expire = init_done && (timer == TIMER_LAST);

  always_ff @(posedge clk_9m) begin
    if (!pll_rst) begin
      for (int unsigned i = 0; i < 8; i++) fbuf[i] <= '0;
    end else if (row_we) begin
      fbuf[row_addr] <= row_data;
    end
  end

  always_ff @(posedge clk_9m) begin
    if (!pll_rst) begin
      state      <= ST_INIT;
      ret_state  <= ST_INIT;
      step       <= '0;
      armed      <= 1'b0;
      init_done  <= 1'b0;
      intens_q   <= INTENSITY;
      int_pend   <= 1'b0;
      frame_pend <= 1'b0;
      timer      <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      armed     <= 1'b1;
      if (step_clr)      step <= '0;
      else if (step_inc) step <= step + 4'd1;
      if (done_set) init_done <= 1'b1;
      // A strobe coinciding with the issuing cycle keeps the flag: the word
      // just started carries the old value, so the new one still goes out.
      if (intensity_we) begin
        intens_q <= intensity;
        int_pend <= 1'b1;
      end else if (int_clr) begin
        int_pend <= 1'b0;
      end
      if (init_done) timer <= expire ? '0 : timer + 1'b1;
      if (expire)       frame_pend <= 1'b1;
      else if (frm_clr) frame_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx   = state;
    ret_nx     = ret_state;
    start      = 1'b0;
    word       = '0;
    step_inc   = 1'b0;
    step_clr   = 1'b0;
    int_clr    = 1'b0;
    frm_clr    = 1'b0;
    done_set   = 1'b0;
    digit_addr = REG_DIGIT0 + step;

    case (state)
      ST_INIT: begin
        if (step == 4'd6) begin
          state_nx = ST_IDLE;
          done_set = 1'b1;
        end else if (armed) begin
          start    = 1'b1;
          step_inc = 1'b1;
          ret_nx   = ST_INIT;
          state_nx = ST_WAIT_WORD;
          case (step)
            4'd0:    word = mk_word(REG_SHUTDOWN, 8'h00);
            4'd1:    word = mk_word(REG_TEST, 8'h00);
            4'd2:    word = mk_word(REG_DECODE, 8'h00);
            4'd3:    word = mk_word(REG_SCANLIMIT, {5'b0, SCAN_LIMIT});
            4'd4: begin
              word    = mk_word(REG_INTENSITY, {4'b0, intens_q});
              int_clr = 1'b1;
            end
            default: word = mk_word(REG_SHUTDOWN, 8'h01);
          endcase
        end
      end
      ST_INTENS: begin
        start    = 1'b1;
        word     = mk_word(REG_INTENSITY, {4'b0, intens_q});
        int_clr  = 1'b1;
        ret_nx   = ST_INTENS;
        state_nx = ST_WAIT_WORD;
      end
      ST_FRAME: begin
        start    = 1'b1;
        word     = mk_word(digit_addr, fbuf[step[2:0]]);
        step_inc = 1'b1;
        frm_clr  = (step == 4'd0);
        ret_nx   = ST_FRAME;
        state_nx = ST_WAIT_WORD;
      end
      ST_WAIT_WORD, ST_IDLE: begin
        if (state == ST_IDLE || shift_done) begin
          if (state == ST_WAIT_WORD && ret_state == ST_INIT) begin
            state_nx = ST_INIT;
          end else if (state == ST_WAIT_WORD && ret_state == ST_FRAME && step != 4'd8) begin
            state_nx = ST_FRAME;
          end else if (int_pend) begin
            state_nx = ST_INTENS;
          end else if (frame_pend) begin
            state_nx = ST_FRAME;
            step_clr = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

endmodule

// File: doc/matrix_seq.md
# matrix_seq

Sequencer for the 8x8 MAX7219-style LED matrix driver in the `clk_9m` domain. It owns the power-up register initialisation, holds an 8-row frame buffer written by the host, and periodically refreshes all eight digit registers over the serial `cs`/`dout` link. The serial clock to the display is `clk_9m` itself. The block sits between host logic and the matrix pins, replacing ad-hoc command generation inside the matrix top.

## Interface
- `INTENSITY`, 4'h8: intensity value used at init until `intensity_we`.
- `SCAN_LIMIT`, 3'd7: value written to the scan-limit register.
- `REFRESH_DIV`, 9000: frame period in cycles. Must satisfy ≥ 9*(16+`GAP_CYCLES`).
- `GAP_CYCLES`, 2: `cs`-high cycles between words. Must be ≥ 1.
- `clk_9m`, in, 1: the single clock. Also the display serial clock.
- `pll_rst`, in, 1: reset. Synchronous, active-low.
- `row_we`, in, 1: frame-buffer write strobe.
- `row_addr`, in, 3: row 0..7.
- `row_data`, in, 8: row pixels.
- `intensity_we`, in, 1: intensity update strobe.
- `intensity`, in, 4: new intensity.
- `busy`, out, 1: a word is in flight (`cs` low or in gap).
- `init_done`, out, 1: init sequence complete.
- `cs`, out, 1: chip select/load. Active low; the display latches the word on the rising edge.
- `dout`, out, 1: serial data, MSB first.

## Operation
- **Reset values:** `cs`=1, `dout`=0, `busy`=0, `init_done`=0, frame buffer all 0, intensity register=`INTENSITY`, pending flags clear, refresh timer 0.
- **Word format:** 16 bits = {4'h0, addr[3:0], data[7:0]}, shifted MSB first.
- **FSM states:** INIT → IDLE ↔ (INTENS, FRAME). WAIT_WORD is entered from any issuing state until the shifter reports done.
- **INIT:** issues six words in order, then enters IDLE and sets `init_done`.
  - 0x0C00 (shutdown)
  - 0x0F00 (test off)
  - 0x0900 (no decode)
  - {0x0B, 5'b0, SCAN_LIMIT}
  - {0x0A, 4'b0, intensity register}
  - 0x0C01 (normal operation)
- **Refresh timer:** starts counting at `init_done`. On reaching `REFRESH_DIV`-1 it wraps to 0 and sets `frame_pend`.
- **FRAME:** eight words, row r → {4'h0, r+1, buffer[r]}, r = 0..7. `frame_pend` clears when row 0 starts.
- **Late frame trigger:** if the timer expires while a frame is still running, `frame_pend` is set and the next frame starts immediately after row 7. At most one pending frame is held; no queue beyond that.
- **Intensity update:**
  - `intensity_we` latches `intensity` and sets `int_pend`.
  - From IDLE, `int_pend` issues {0x0A, 4'b0, value} before any pending frame.
  - An update arriving mid-frame is issued after row 7.
  - During INIT, the latched value replaces the init value if that word has not started yet, and `int_pend` is cleared.
- **Frame-buffer writes:** `row_we` writes take effect the next cycle. Each word samples its buffer row at word start, so a write to a row currently being shifted appears only in the next frame.
- **Simultaneous `row_we` and refresh start on the same row:** the old data is sent.
- **Reset mid-operation:** sampled `pll_rst`=0 forces all reset values on that edge. `cs` rises immediately and the sequence restarts from INIT.

## Timing
- **Start after reset:** the first edge sampling `pll_rst`=1 is cycle 0. `cs` falls and bit15 appears on `dout` after edge 1.
- **Per word:** `cs` low for exactly 16 cycles, with bit 15-k driven in low-cycle k. `cs` then rises and `dout` returns to 0. `cs` stays high for `GAP_CYCLES` cycles before the next word can fall.
- **Word period:** 16+`GAP_CYCLES` cycles.
- **`busy`:** high from `cs` fall through the final gap cycle.
- **`init_done`:** rises on the edge ending the 6th word's gap.
- **Back-to-back words:** no idle cycles beyond the gap.
- **IDLE to issue:** a word starts on the cycle after a pending flag is observed in IDLE.

## Structure
- Package `matrix_pkg` holds:
  - Register address constants: REG_DIGIT0=4'h1, REG_DECODE=4'h9, REG_INTENSITY=4'hA, REG_SCANLIMIT=4'hB, REG_SHUTDOWN=4'hC, REG_TEST=4'hF.
  - `typedef logic [15:0] mword_t`.
  - The FSM state enum.
- Sub-module `matrix_shift`: 16-bit serializer with a `start`/`word` input and `done` pulse. It owns `cs`, `dout` and the gap counter.
- `matrix_seq` owns the FSM, frame buffer, refresh timer and pending flags.

## Test plan
- **Reset release, defaults:** `cs` words 0x0C00, 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01, each with 16 low cycles and a gap of 2. `init_done` is high after the 6th gap.
- **Row write before first frame:** write row 3=0xA5 → first frame is 0x0100, 0x0200, 0x0300, 0x04A5, 0x0500..0x0800.
- **Intensity update mid-frame:** `intensity_we` with 4'h3 during row 2 → 0x0A03 sent exactly once after row 7, before the next frame's 0x01xx.
- **Reset mid-word:** `pll_rst`=0 after 7 bits of a row word → `cs`=1 and `dout`=0 the next cycle. After release, the sequence restarts with 0x0C00.
- **Minimum refresh period:** `REFRESH_DIV`=9*(16+GAP) → frames are back-to-back with no missed frame and no extra idle cycles.
- **Write during shift:** `row_we` to row 5 while 0x06xx is being shifted → that word carries the old data. The next frame carries the new data.
